// File: rtl/pll_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pll_ctrl_pkg : shared types and default timing for the ECP5 PLL phase control.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SETUP    = 3'd1,
      ST_PULSE_HI = 3'd2,
      ST_PULSE_LO = 3'd3,
      ST_SETTLE   = 3'd4,
      ST_DONE     = 3'd5
   } pll_state_e;

   localparam int C_SETUP_CYC       = 4;
   localparam int C_STEP_HI_CYC     = 4;
   localparam int C_STEP_LO_CYC     = 4;
   localparam int C_SETTLE_CYC      = 16;
   localparam int C_LOCK_STABLE_CYC = 1024;
   localparam int C_STEPS_W         = 8;

   // ecp5pll output indices as seen on phasesel
   localparam logic [1:0] SHIFT = 2'd0;
   localparam logic [1:0] PIXEL = 2'd1;
   localparam logic [1:0] CPU   = 2'd2;
   localparam logic [1:0] SPARE = 2'd3;

   function automatic int max_of4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// -----------------------------------------------------------------------------
// pll_lock_supervisor : synchronises PLL locked and qualifies it as clk_ok.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pll_lock_supervisor
   import pll_ctrl_pkg::*;
#(
   parameter int LOCK_STABLE_CYC = C_LOCK_STABLE_CYC
) (
   input  logic clk_i,
   input  logic reset,
   input  logic locked_i,
   output logic lk,
   output logic clk_ok
);

   localparam int CW = $clog2(LOCK_STABLE_CYC + 1);
   localparam logic [CW-1:0] STABLE_MAX = CW'(LOCK_STABLE_CYC);
   localparam logic [CW-1:0] STABLE_ONE = CW'(1);

   logic          meta_q, meta_d;
   logic          lk_q, lk_d;
   logic [CW-1:0] stable_q, stable_d;

   always_comb begin
      meta_d   = locked_i;
      lk_d     = meta_q;
      stable_d = stable_q;
      if (!lk_q) begin
         stable_d = '0;
      end else if (stable_q != STABLE_MAX) begin
         stable_d = stable_q + STABLE_ONE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         meta_q   <= 1'b0;
         lk_q     <= 1'b0;
         stable_q <= '0;
      end else begin
         meta_q   <= meta_d;
         lk_q     <= lk_d;
         stable_q <= stable_d;
      end
   end

   // gated by lk_q so clk_ok falls in the same cycle lock is seen missing
   assign lk     = lk_q;
   assign clk_ok = lk_q && (stable_q == STABLE_MAX);

endmodule

`default_nettype wire

// File: rtl/pll_phase_sequencer.sv
// -----------------------------------------------------------------------------
// pll_phase_sequencer : drives the ecp5pll dynamic phase-shift port per request.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module pll_phase_sequencer
   import pll_ctrl_pkg::*;
#(
   parameter int SETUP_CYC       = C_SETUP_CYC,
   parameter int STEP_HI_CYC     = C_STEP_HI_CYC,
   parameter int STEP_LO_CYC     = C_STEP_LO_CYC,
   parameter int SETTLE_CYC      = C_SETTLE_CYC,
   parameter int LOCK_STABLE_CYC = C_LOCK_STABLE_CYC,
   parameter int STEPS_W         = C_STEPS_W
) (
   input  logic               clk_i,
   input  logic               reset,
   input  logic               locked_i,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_sel,
   input  logic               req_dir,
   input  logic [STEPS_W-1:0] req_steps,
   output logic [1:0]         phasesel,
   output logic               phasedir,
   output logic               phasestep,
   output logic               phaseloadreg,
   output logic               busy,
   output logic               done,
   output logic               lock_lost,
   output logic               clk_ok,
   output logic [STEPS_W-1:0] steps_done
);

   localparam int MAX_CYC = max_of4(SETUP_CYC, STEP_HI_CYC, STEP_LO_CYC, SETTLE_CYC);
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0]   SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0]   HI_LAST     = CNT_W'(STEP_HI_CYC - 1);
   localparam logic [CNT_W-1:0]   LO_LAST     = CNT_W'(STEP_LO_CYC - 1);
   localparam logic [CNT_W-1:0]   SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
   localparam logic [STEPS_W-1:0] STEPS_ONE   = STEPS_W'(1);

   pll_state_e         state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [STEPS_W-1:0] remaining_q, remaining_d;
   logic [STEPS_W-1:0] steps_done_q, steps_done_d;
   logic [1:0]         phasesel_q, phasesel_d;
   logic               phasedir_q, phasedir_d;
   logic               phasestep_q, phasestep_d;
   logic               lock_lost_q, lock_lost_d;

   logic               lk;
   logic               accept;
   logic               abort;

   pll_lock_supervisor #(
      .LOCK_STABLE_CYC (LOCK_STABLE_CYC)
   ) u_lock_supervisor (
      .clk_i    (clk_i),
      .reset    (reset),
      .locked_i (locked_i),
      .lk       (lk),
      .clk_ok   (clk_ok)
   );

   assign accept = req_valid && req_ready;
   // losing lock while stepping invalidates the shift; SETTLE merely waits
   assign abort  = !lk && ((state_q == ST_SETUP) || (state_q == ST_PULSE_HI) ||
                           (state_q == ST_PULSE_LO));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      remaining_d  = remaining_q;
      steps_done_d = steps_done_q;
      phasesel_d   = phasesel_q;
      phasedir_d   = phasedir_q;
      lock_lost_d  = lock_lost_q;

      if (abort) begin
         state_d     = ST_IDLE;
         cnt_d       = '0;
         lock_lost_d = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  phasesel_d   = req_sel;
                  phasedir_d   = req_dir;
                  steps_done_d = '0;
                  lock_lost_d  = 1'b0;
                  remaining_d  = req_steps;
                  cnt_d        = '0;
                  state_d      = (req_steps == '0) ? ST_SETTLE : ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt_q == SETUP_LAST) begin
                  cnt_d   = '0;
                  state_d = ST_PULSE_HI;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_PULSE_HI: begin
               if (cnt_q == HI_LAST) begin
                  cnt_d       = '0;
                  remaining_d = remaining_q - STEPS_ONE;
                  state_d     = ST_PULSE_LO;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_PULSE_LO: begin
               if (cnt_q == LO_LAST) begin
                  cnt_d = '0;
                  if (steps_done_q != '1) begin
                     steps_done_d = steps_done_q + STEPS_ONE;
                  end
                  state_d = (remaining_q == '0) ? ST_SETTLE : ST_PULSE_HI;
               end else begin
                  cnt_d = cnt_q + CNT_ONE;
               end
            end
            ST_SETTLE: begin
               if (clk_ok) begin
                  if (cnt_q == SETTLE_LAST) begin
                     cnt_d   = '0;
                     state_d = ST_DONE;
                  end else begin
                     cnt_d = cnt_q + CNT_ONE;
                  end
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         endcase
      end

      phasestep_d = (state_d == ST_PULSE_HI);
   end

   always_ff @(posedge clk_i) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         remaining_q  <= '0;
         steps_done_q <= '0;
         phasesel_q   <= 2'd0;
         phasedir_q   <= 1'b0;
         phasestep_q  <= 1'b0;
         lock_lost_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         remaining_q  <= remaining_d;
         steps_done_q <= steps_done_d;
         phasesel_q   <= phasesel_d;
         phasedir_q   <= phasedir_d;
         phasestep_q  <= phasestep_d;
         lock_lost_q  <= lock_lost_d;
      end
   end

   assign req_ready    = (state_q == ST_IDLE) && clk_ok;
   assign phasesel     = phasesel_q;
   assign phasedir     = phasedir_q;
   assign phasestep    = phasestep_q;
   assign phaseloadreg = 1'b0;
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_DONE);
   assign lock_lost    = lock_lost_q;
   assign steps_done   = steps_done_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pll_phase_sequencer : directed tables, corner sequences and random traffic.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_pll_phase_sequencer;
   import pll_ctrl_pkg::*;

   localparam int C_SETUP  = 4;
   localparam int C_HI     = 4;
   localparam int C_LO     = 4;
   localparam int C_SETTLE = 16;
   localparam int C_LOCK   = 1024;
   localparam int C_PER    = C_HI + C_LO;

   logic       clk_i     = 1'b0;
   logic       reset     = 1'b1;
   logic       locked_i  = 1'b0;
   logic       req_valid = 1'b0;
   logic [1:0] req_sel   = 2'd0;
   logic       req_dir   = 1'b0;
   logic [7:0] req_steps = 8'd0;

   logic       req_ready, phasedir, phasestep, phaseloadreg, busy, done, lock_lost, clk_ok;
   logic [1:0] phasesel;
   logic [7:0] steps_done;
   logic [17:0] act_v;

   int n_checks = 0;
   int n_errors = 0;

   pll_phase_sequencer dut (
      .clk_i        (clk_i),
      .reset        (reset),
      .locked_i     (locked_i),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_sel      (req_sel),
      .req_dir      (req_dir),
      .req_steps    (req_steps),
      .phasesel     (phasesel),
      .phasedir     (phasedir),
      .phasestep    (phasestep),
      .phaseloadreg (phaseloadreg),
      .busy         (busy),
      .done         (done),
      .lock_lost    (lock_lost),
      .clk_ok       (clk_ok),
      .steps_done   (steps_done)
   );

   always #20 clk_i = ~clk_i;

   assign act_v = {req_ready, phasesel, phasedir, phasestep, phaseloadreg,
                   busy, done, lock_lost, clk_ok, steps_done};

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Reference model: a request is an elapsed-time line e (edges since
   // acceptance); pulses, step count and done fall out of arithmetic on e.
   int       m_run  = 0;
   bit       m_lk   = 1'b0;
   bit       m_ok   = 1'b0;
   bit       m_busy = 1'b0;
   bit       m_lost = 1'b0;
   bit       m_dir  = 1'b0;
   bit [1:0] m_sel  = 2'd0;
   int       m_e    = 0;
   int       m_n    = 0;
   int       m_sd   = 0;

   function automatic int settle_start(input int n);
      return (n == 0) ? 0 : C_SETUP + C_PER * n;
   endfunction

   function automatic int done_at(input int n);
      return settle_start(n) + C_SETTLE;
   endfunction

   function automatic int pulses_at(input int e, input int n);
      int p;
      if (n == 0 || e < C_SETUP) return 0;
      p = (e - C_SETUP) / C_PER;
      return (p > n) ? n : p;
   endfunction

   function automatic bit step_at(input int e, input int n);
      return (n > 0) && (e >= C_SETUP) && (e < C_SETUP + C_PER * n) &&
             (((e - C_SETUP) % C_PER) < C_HI);
   endfunction

   initial begin
      bit lk_b, ok_b;
      forever begin
         @(posedge clk_i);
         lk_b = m_lk;
         ok_b = m_ok;
         if (reset) begin
            m_run = 0; m_lk = 0; m_ok = 0; m_busy = 0; m_lost = 0;
            m_sel = 0; m_dir = 0; m_e = 0; m_n = 0; m_sd = 0;
         end else begin
            // lock seen two samples late; qualified after C_LOCK+1 high samples
            m_lk  = (m_run >= 1);
            m_ok  = (m_run >= C_LOCK + 1);
            m_run = locked_i ? ((m_run < 4 * C_LOCK) ? m_run + 1 : m_run) : 0;
            if (!m_busy) begin
               if (req_valid && ok_b) begin
                  m_busy = 1; m_e = 0; m_n = int'(req_steps);
                  m_sel = req_sel; m_dir = req_dir; m_lost = 0;
               end
            end else if (m_e == done_at(m_n)) begin
               m_busy = 0;
            end else if (m_e < settle_start(m_n)) begin
               if (!lk_b) begin
                  m_busy = 0;
                  m_lost = 1;
               end else begin
                  m_e++;
               end
            end else if (ok_b) begin
               m_e++;
            end
            if (m_busy) m_sd = pulses_at(m_e, m_n);
         end
      end
   end

   initial begin
      logic [17:0] exp_v;
      forever begin
         @(negedge clk_i);
         exp_v = {(!m_busy && m_ok), m_sel, m_dir, (m_busy && step_at(m_e, m_n)), 1'b0,
                  m_busy, (m_busy && (m_e == done_at(m_n))), m_lost, m_ok, 8'(m_sd)};
         check("outputs_vs_model", int'(act_v), int'(exp_v));
      end
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
      $fatal(1);
   end

   task automatic wait_ready();
      int guard;
      guard = 0;
      while (!req_ready && guard < 3000) begin
         @(negedge clk_i);
         guard++;
      end
      check("ready_wait", int'(req_ready), 1);
   endtask

   // Issues one request and returns cycles to done (acceptance edge = cycle 0).
   task automatic run_request(input logic [1:0] sel, input logic dir, input logic [7:0] steps,
                              output int lat, output int first_hi, output int npulses);
      logic prev;
      wait_ready();
      req_sel = sel; req_dir = dir; req_steps = steps; req_valid = 1'b1;
      @(negedge clk_i);
      req_valid = 1'b0;
      lat = 1; first_hi = 0; npulses = 0; prev = 1'b0;
      while (1) begin
         if (phasestep && !prev) begin
            npulses++;
            if (first_hi == 0) first_hi = lat;
         end
         prev = phasestep;
         if (done || lat >= 5000) break;
         @(negedge clk_i);
         lat++;
      end
   endtask

   typedef struct {
      logic [1:0] sel;
      logic       dir;
      logic [7:0] steps;
      int         lat;
      int         first_hi;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int lat, first_hi, npulses, k, low_left, drops;
      logic prev, seen;

      vecs[0] = '{PIXEL, 1'b0, 8'd3,   45,   5};
      vecs[1] = '{CPU,   1'b1, 8'd0,   17,   0};
      vecs[2] = '{SHIFT, 1'b1, 8'd1,   29,   5};
      vecs[3] = '{SPARE, 1'b0, 8'd2,   37,   5};
      vecs[4] = '{PIXEL, 1'b1, 8'd255, 2061, 5};

      // reset with lock already present
      reset = 1'b1; locked_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check("reset_outputs", int'(act_v), 0);
      reset = 1'b0;
      k = 0;
      while (!clk_ok && k < 1200) begin
         @(negedge clk_i);
         k++;
      end
      check("clk_ok_rise_cycle", k, 1026);
      check("ready_with_clk_ok", int'(req_ready), 1);

      for (int i = 0; i < 5; i++) begin
         run_request(vecs[i].sel, vecs[i].dir, vecs[i].steps, lat, first_hi, npulses);
         check("done_latency", lat, vecs[i].lat);
         check("first_pulse_cycle", first_hi, vecs[i].first_hi);
         check("pulse_count", npulses, int'(vecs[i].steps));
         check("steps_done_at_done", int'(steps_done), int'(vecs[i].steps));
         check("phasesel_held", int'(phasesel), int'(vecs[i].sel));
         check("phasedir_held", int'(phasedir), int'(vecs[i].dir));
         @(negedge clk_i);
         check("done_single_cycle", int'(done), 0);
      end

      // lock lost during the second high pulse
      wait_ready();
      req_sel = SPARE; req_dir = 1'b1; req_steps = 8'd3; req_valid = 1'b1;
      @(negedge clk_i);
      req_valid = 1'b0;
      k = 0; npulses = 0; prev = phasestep;
      if (phasestep) npulses = 1;
      while (npulses < 2 && k < 200) begin
         @(negedge clk_i);
         k++;
         if (phasestep && !prev) npulses++;
         prev = phasestep;
      end
      locked_i = 1'b0;
      k = 0;
      while (phasestep && k < 10) begin
         @(negedge clk_i);
         k++;
      end
      check("abort_step_fall_cycles", k, 3);
      check("abort_lock_lost", int'(lock_lost), 1);
      check("abort_steps_done", int'(steps_done), 1);
      check("abort_busy", int'(busy), 0);
      check("abort_ready", int'(req_ready), 0);
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk_i);
         if (done) seen = 1'b1;
      end
      check("abort_no_done", int'(seen), 0);
      locked_i = 1'b1;
      k = 0;
      while (!clk_ok && k < 1200) begin
         @(negedge clk_i);
         k++;
      end
      check("relock_ready", int'(req_ready), 1);

      // short lock glitch while settling stretches the wait only
      wait_ready();
      req_sel = CPU; req_dir = 1'b0; req_steps = 8'd1; req_valid = 1'b1;
      @(negedge clk_i);
      req_valid = 1'b0;
      lat = 1; seen = 1'b0;
      while (lat < 20) begin
         @(negedge clk_i);
         lat++;
      end
      locked_i = 1'b0;
      repeat (5) begin
         @(negedge clk_i);
         lat++;
      end
      locked_i = 1'b1;
      while (!done && lat < 3000) begin
         @(negedge clk_i);
         lat++;
         if (lock_lost) seen = 1'b1;
      end
      check("settle_glitch_latency", lat, 29 + 1029);
      check("settle_glitch_no_lock_lost", int'(seen), 0);
      check("settle_glitch_steps_done", int'(steps_done), 1);

      // reset in the middle of a pulse, request held across it
      wait_ready();
      req_sel = PIXEL; req_dir = 1'b1; req_steps = 8'd2; req_valid = 1'b1;
      @(negedge clk_i);
      req_valid = 1'b0;
      k = 0;
      while (!phasestep && k < 20) begin
         @(negedge clk_i);
         k++;
      end
      reset = 1'b1; req_valid = 1'b1;
      @(negedge clk_i);
      check("reset_mid_pulse_outputs", int'(act_v), 0);
      reset = 1'b0;
      k = 0;
      while (!busy && k < 1200) begin
         @(negedge clk_i);
         k++;
      end
      check("reaccept_after_reset_cycle", k, 1027);
      req_valid = 1'b0;
      k = 0;
      while (!done && k < 200) begin
         @(negedge clk_i);
         k++;
      end
      check("reaccept_steps_done", int'(steps_done), 2);

      // random traffic with requests while busy and occasional lock loss
      low_left = 0; drops = 0;
      for (int c = 0; c < 7000; c++) begin
         req_valid = ($urandom_range(0, 3) == 0);
         req_sel   = 2'($urandom);
         req_dir   = 1'($urandom);
         req_steps = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 12));
         if (low_left > 0) begin
            low_left--;
            if (low_left == 0) locked_i = 1'b1;
         end else if ((c % 1700 == 900) || (drops < 6 && $urandom_range(0, 1999) == 0)) begin
            locked_i = 1'b0;
            low_left = $urandom_range(1, 6);
            drops++;
         end
         @(negedge clk_i);
      end
      req_valid = 1'b0;
      locked_i  = 1'b1;
      k = 0;
      while ((busy || !clk_ok) && k < 3000) begin
         @(negedge clk_i);
         k++;
      end
      check("final_idle_ready", int'(req_ready), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
